// File: rtl/bin_to_bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int unsigned BCD_W       = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;
  localparam logic [3:0]  ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// before the shift (4-bit wrap, no carry out).
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] dig_i,
  output logic [BCD_W-1:0] adj_c
);

  always_comb begin
    adj_c = dig_i;
    if (dig_i >= ADD3_THRESH) begin
      adj_c = dig_i + ADD3_VAL;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a single-entry pending slot for requests arriving mid-conversion.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [WIDTH-1:0]          Dato,
  input  logic                      Cargar,
  output logic [BCD_W*DIGITS-1:0]   Bcd,
  output logic                      Listo,
  output logic                      Ocupado
);

  localparam int unsigned BCD_TOT = BCD_W * DIGITS;
  localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_TOT-1:0] scr_q, scr_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [BCD_TOT-1:0] bcd_q, bcd_d;
  logic               listo_q, listo_d;
  logic               ocupado_q, ocupado_d;

  logic [BCD_TOT-1:0]       scr_adj;
  logic [BCD_TOT+WIDTH-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .dig_i (scr_q[g*BCD_W +: BCD_W]),
      .adj_c (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  assign shifted = {scr_adj, shift_q} << 1;

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    scr_d      = scr_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bcd_d      = bcd_q;
    listo_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Cargar) begin
          shift_d = Dato;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, shift_d} = shifted;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
        if (Cargar) begin
          pend_d     = Dato;
          pend_vld_d = 1'b1;
        end
      end
      DONE: begin
        bcd_d      = scr_q;
        listo_d    = 1'b1;
        pend_vld_d = 1'b0;
        scr_d      = '0;
        cnt_d      = CNT_W'(WIDTH - 1);
        // A fresh request supersedes anything left in the pending slot
        if (Cargar) begin
          shift_d = Dato;
          state_d = SHIFT;
        end else if (pend_vld_q) begin
          shift_d = pend_q;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scr_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bcd_q      <= '0;
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      scr_q      <= scr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bcd_q      <= bcd_d;
      listo_q    <= listo_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign Bcd     = bcd_q;
  assign Listo   = listo_q;
  assign Ocupado = ocupado_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3).
module tb_bin_to_bcd_seq;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  Dato;
  logic        Cargar;
  logic [11:0] Bcd;
  logic        Listo;
  logic        Ocupado;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Dato    (Dato),
    .Cargar  (Cargar),
    .Bcd     (Bcd),
    .Listo   (Listo),
    .Ocupado (Ocupado)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  dato;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] d);
    Dato   = d;
    Cargar = 1'b1;
    tick();
    Cargar = 1'b0;
  endtask

  // Counts edges until Listo rises (bounded); flags any Bcd change beforehand.
  task automatic wait_listo(output int lat, output logic held_ok);
    logic [11:0] prev;
    prev    = Bcd;
    held_ok = 1'b1;
    lat     = 0;
    do begin
      tick();
      lat++;
      if (!Listo && Bcd !== prev) held_ok = 1'b0;
    end while (!Listo && lat < 30);
  endtask

  initial begin
    int   lat;
    int   cnt;
    logic held;

    vecs[0] = '{8'hA9, 12'h169};
    vecs[1] = '{8'hFF, 12'h255};
    vecs[2] = '{8'h00, 12'h000};
    vecs[3] = '{8'h01, 12'h001};
    vecs[4] = '{8'h64, 12'h100};
    vecs[5] = '{8'h63, 12'h099};
    vecs[6] = '{8'h0A, 12'h010};
    vecs[7] = '{8'hC8, 12'h200};

    Rst_n  = 1'b0;
    Cargar = 1'b0;
    Dato   = 8'h00;
    tick();
    tick();
    check("reset_bcd", 32'(Bcd), 32'h0);
    check("reset_listo", 32'(Listo), 32'h0);
    check("reset_ocupado", 32'(Ocupado), 32'h0);
    Rst_n = 1'b1;
    tick();

    // Table of single conversions
    foreach (vecs[i]) begin
      start(vecs[i].dato);
      check($sformatf("vec%0d_ocupado_busy", i), 32'(Ocupado), 32'h1);
      wait_listo(lat, held);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      check($sformatf("vec%0d_bcd", i), 32'(Bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_bcd_held", i), 32'(held), 32'h1);
      tick();
      check($sformatf("vec%0d_listo_pulse", i), 32'(Listo), 32'h0);
      check($sformatf("vec%0d_ocupado_idle", i), 32'(Ocupado), 32'h0);
      check($sformatf("vec%0d_bcd_hold", i), 32'(Bcd), 32'(vecs[i].exp_bcd));
    end

    // Busy requests: latest pending wins, 8'h31 never appears
    start(8'h19);                     // edge T
    tick();                           // T+1
    Dato = 8'h31; Cargar = 1'b1;
    tick();                           // T+2
    Cargar = 1'b0;
    tick();                           // T+3
    Dato = 8'h79; Cargar = 1'b1;
    tick();                           // T+4
    Cargar = 1'b0;
    for (int k = 0; k < 5; k++) tick();  // T+9
    check("pend_first_listo", 32'(Listo), 32'h1);
    check("pend_first_bcd", 32'(Bcd), 32'h025);
    check("pend_restart_busy", 32'(Ocupado), 32'h1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin   // T+10..T+17
      tick();
      if (Listo || Bcd !== 12'h025) cnt++;
    end
    check("pend_gap_quiet", 32'(cnt), 32'd0);
    tick();                           // T+18
    check("pend_second_listo", 32'(Listo), 32'h1);
    check("pend_second_bcd", 32'(Bcd), 32'h121);
    tick();
    check("pend_end_idle", 32'(Ocupado), 32'h0);

    // Request in DONE overrides pending value
    start(8'h10);                     // T
    tick(); tick();                   // T+2
    Dato = 8'h63; Cargar = 1'b1;
    tick();                           // T+3
    Cargar = 1'b0;
    for (int k = 0; k < 5; k++) tick();  // T+8: now in DONE
    Dato = 8'h04; Cargar = 1'b1;
    tick();                           // T+9
    Cargar = 1'b0;
    check("ovr_first_bcd", 32'(Bcd), 32'h016);
    for (int k = 0; k < 9; k++) tick();  // T+18
    check("ovr_second_listo", 32'(Listo), 32'h1);
    check("ovr_second_bcd", 32'(Bcd), 32'h004);
    tick();
    check("ovr_pending_dropped", 32'(Ocupado), 32'h0);

    // Cargar held high: one result every 9 cycles
    Dato = 8'h2A; Cargar = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_listo(lat, held);
      check($sformatf("cont%0d_period", k), 32'(lat), 32'd9);
      check($sformatf("cont%0d_bcd", k), 32'(Bcd), 32'h042);
    end
    Cargar = 1'b0;
    wait_listo(lat, held);
    check("cont_drain_bcd", 32'(Bcd), 32'h042);
    tick();
    check("cont_drain_idle", 32'(Ocupado), 32'h0);

    // Reset mid-conversion discards the partial result
    start(8'hFF);                     // T
    for (int k = 0; k < 4; k++) tick();  // T+4
    Rst_n = 1'b0;
    tick();                           // T+5
    check("midrst_bcd", 32'(Bcd), 32'h0);
    check("midrst_listo", 32'(Listo), 32'h0);
    check("midrst_ocupado", 32'(Ocupado), 32'h0);
    Rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (Listo || Ocupado) cnt++;
    end
    check("midrst_no_listo", 32'(cnt), 32'd0);
    start(8'h2D);
    wait_listo(lat, held);
    check("midrst_fresh_lat", 32'(lat), 32'd9);
    check("midrst_fresh_bcd", 32'(Bcd), 32'h045);
    tick();

    // Exhaustive sweep against arithmetic reference
    for (int v = 0; v < 256; v++) begin
      start(8'(v));
      wait_listo(lat, held);
      check($sformatf("sweep%0d_bcd", v), 32'(Bcd), 32'(ref_bcd(v)));
      check($sformatf("sweep%0d_lat", v), 32'(lat), 32'd9);
      tick();
      check($sformatf("sweep%0d_once", v), 32'(Listo), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
